// File: rtl/led_gpio_pkg.sv
// Shared constants for the LED GPIO register block: register map, CTRL bit
// positions, FSM encoding and the blink word composition helper.
package led_gpio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_BLINK  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_REFRESH_BIT = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  // Masked LEDs are dark while the blink phase is high.
  function automatic logic [31:0] compose_word(input logic [31:0] data,
                                               input logic [31:0] mask,
                                               input logic        phase);
    return data & ~(mask & {32{phase}});
  endfunction

endpackage

// File: rtl/led_gpio_ctrl_tick_gen.sv
// tick_gen: free-running divider, one-cycle tick every PERIOD cycles.
// Down-counter reloaded at terminal count; first tick one cycle after reset.
module tick_gen
  import led_gpio_pkg::*;
#(
  parameter int PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            W      = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0]  RELOAD = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == '0) begin
      cnt  <= RELOAD;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt - W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_gpio_ctrl.sv
// led_gpio_ctrl: CPU-visible LED registers feeding the serial shifter with a
// rate-limited Start pulse. Define LED_BLINK_EN to build BLINK_MASK and the blink divider.
module led_gpio_ctrl
  import led_gpio_pkg::*;
#(
  parameter int SHIFT_CYCLES   = 80,
  parameter int REFRESH_CYCLES = 1_000_000,
  parameter int BLINK_CYCLES   = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] P_Data,
  output logic        Start,
  output logic        EN
);

  // state | meaning
  // IDLE  | nothing in flight, waits for pending && EN
  // SEND  | Start high, P_Data holds the fresh snapshot
  // GUARD | shifter still busy; new triggers coalesce into pending

  localparam int           GW         = $clog2(SHIFT_CYCLES);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(SHIFT_CYCLES - 2);

  logic [31:0]   data_q, data_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [31:0]   p_data_q;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] guard_q;
  logic          pending_q;
  logic          refresh_tick;
  logic          blink_trig;
  logic          trig;
  logic          want;
  logic [31:0]   word_d;

  tick_gen #(.PERIOD(REFRESH_CYCLES)) u_refresh_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (refresh_tick)
  );

  assign data_d = (we && addr == ADDR_DATA) ? wdata : data_q;
  assign ctrl_d = (we && addr == ADDR_CTRL) ? wdata[1:0] : ctrl_q;

`ifdef LED_BLINK_EN
  logic [31:0] mask_q, mask_d;
  logic        phase_q, phase_d;
  logic        blink_tick;

  tick_gen #(.PERIOD(BLINK_CYCLES)) u_blink_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (blink_tick)
  );

  assign mask_d     = (we && addr == ADDR_BLINK) ? wdata : mask_q;
  assign phase_d    = phase_q ^ blink_tick;
  assign blink_trig = blink_tick & (mask_q != '0);
  assign word_d     = compose_word(data_d, mask_d, phase_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      phase_q <= phase_d;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (BLINK_CYCLES != 0);
  assign blink_trig   = 1'b0;
  assign word_d       = data_d;
`endif

  // Snapshot and enable use post-write values so a write lands in the very next Start.
  assign trig = (we && addr != ADDR_STATUS)
              | (refresh_tick & ctrl_q[CTRL_REFRESH_BIT])
              | blink_trig;
  assign want = (pending_q | trig) & ctrl_d[CTRL_EN_BIT];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (want) state_d = ST_SEND;
      ST_SEND:  state_d = ST_GUARD;
      ST_GUARD: if (guard_q == '0) state_d = want ? ST_SEND : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      ctrl_q    <= '0;
      state_q   <= ST_IDLE;
      guard_q   <= '0;
      pending_q <= 1'b1;
      p_data_q  <= '0;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      if (state_d == ST_SEND) p_data_q <= word_d;
      case (state_q)
        ST_SEND: begin
          pending_q <= trig;
          guard_q   <= GUARD_LOAD;
        end
        ST_GUARD: begin
          pending_q <= pending_q | trig;
          if (guard_q != '0) guard_q <= guard_q - GW'(1);
        end
        default: pending_q <= pending_q | trig;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:   rdata = data_q;
      ADDR_CTRL:   rdata = {30'd0, ctrl_q};
`ifdef LED_BLINK_EN
      ADDR_BLINK:  rdata = mask_q;
`endif
      ADDR_STATUS: rdata = {30'd0, pending_q, state_q != ST_IDLE};
      default:     rdata = '0;
    endcase
  end

  assign P_Data = p_data_q;
  assign Start  = (state_q == ST_SEND);
  assign EN     = ctrl_q[CTRL_EN_BIT];

endmodule

// File: tb/tb_led_gpio_ctrl.sv
// Testbench for led_gpio_ctrl: directed scenarios plus randomized register
// traffic checked against a transfer-level reference model.
module tb_led_gpio_ctrl;

  localparam int S = 16;
  localparam int R = 200;
  localparam int B = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] P_Data;
  logic        Start;
  logic        EN;

  always #5 clk = ~clk;

  led_gpio_ctrl #(
    .SHIFT_CYCLES   (S),
    .REFRESH_CYCLES (R),
    .BLINK_CYCLES   (B)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .P_Data (P_Data),
    .Start  (Start),
    .EN     (EN)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: transfer-level view (last Start cycle, pending flag, registers).
  int          cyc;
  logic [31:0] m_data;
  logic [1:0]  m_ctrl;
  logic [31:0] m_pdata;
  bit          m_pend;
  bit          m_start;
  int          m_last;
  bit          model_on;

  int          starts_q[$];
  logic [31:0] sdata_q[$];
  logic [31:0] obs_rdata;
  logic [31:0] obs_pdata;

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    bit busy;
    busy = (cyc >= m_last) && (cyc <= m_last + S - 1);
    case (a)
      2'd0:    return m_data;
      2'd1:    return {30'd0, m_ctrl};
      2'd3:    return {30'd0, m_pend, busy};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_data  = '0;
    m_ctrl  = '0;
    m_pdata = '0;
    m_pend  = 1'b1;
    m_start = 1'b0;
    m_last  = -1000;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
    for (int i = 0; i < n; i++) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cyc = cyc + n;
  endtask

  task automatic step(input bit w, input logic [1:0] a, input logic [31:0] d);
    bit p;
    bit t;
    we = w; addr = a; wdata = d;
    @(negedge clk);
    obs_rdata = rdata;
    obs_pdata = P_Data;
    if (model_on) begin
      check("start", {31'd0, Start}, {31'd0, m_start});
      check("p_data", P_Data, m_pdata);
      check("en", {31'd0, EN}, {31'd0, m_ctrl[0]});
      check("rdata", rdata, model_rdata(a));
    end
    if (Start) begin
      starts_q.push_back(cyc);
      sdata_q.push_back(P_Data);
    end
    p = m_start ? 1'b0 : m_pend;
    t = 1'b0;
    if (w) begin
      case (a)
        2'd0: begin m_data = d; t = 1'b1; end
        2'd1: begin m_ctrl = d[1:0]; t = 1'b1; end
        2'd2: t = 1'b1;
        default: ;
      endcase
    end
    p = p | t;
    m_pend  = p;
    m_start = p && m_ctrl[0] && (cyc + 1 >= m_last + S);
    if (m_start) begin
      m_pdata = m_data;
      m_last  = cyc + 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0;
    int          n0;
    logic [31:0] v3;
    logic [1:0]  a;
    logic [31:0] d;

    rst = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
    cyc = 0;
    model_on = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    // Reset state and first enable clears the LEDs.
    step(0, 2'd3, 32'd0);
    check("reset_status", obs_rdata, 32'h2);
    check("reset_pdata", obs_pdata, 32'h0);
    t0 = cyc;
    step(1, 2'd1, 32'd1);
    step(0, 2'd0, 32'd0);
    check("en_start_cycle", starts_q.size() > 0 ? 32'(starts_q[$]) : 32'hFFFF_FFFF, 32'(t0 + 1));
    check("en_start_data", obs_pdata, 32'h0);
    for (int i = 0; i < S; i++) step(0, 2'd3, 32'd0);

    // Single write while idle.
    t0 = cyc;
    step(1, 2'd0, 32'hA5A5_0F0F);
    step(0, 2'd3, 32'd0);
    check("data_start_cycle", starts_q.size() > 0 ? 32'(starts_q[$]) : 32'hFFFF_FFFF, 32'(t0 + 1));
    check("data_pdata", obs_pdata, 32'hA5A5_0F0F);
    for (int i = 0; i < S - 1; i++) begin
      step(0, 2'd3, 32'd0);
      check("guard_status", obs_rdata, 32'h1);
    end

    // Three writes inside one guard window coalesce into one transfer.
    v3 = $urandom;
    n0 = starts_q.size();
    t0 = cyc;
    for (int i = 0; i < 2 * S + 3; i++) begin
      if (i == 0)       step(1, 2'd0, 32'h1111_1111);
      else if (i == 3)  step(1, 2'd0, 32'h2222_2222);
      else if (i == 8)  step(1, 2'd0, 32'h3333_3333);
      else if (i == 13) step(1, 2'd0, v3);
      else              step(0, 2'd3, 32'd0);
    end
    check("coalesce_count", 32'(starts_q.size() - n0), 32'd2);
    if (starts_q.size() - n0 >= 2) begin
      check("coalesce_cycle", 32'(starts_q[n0 + 1]), 32'(t0 + 1 + S));
      check("coalesce_data", sdata_q[n0 + 1], v3);
    end

    // Randomized register traffic; auto-refresh kept off so the model is exact.
    for (int i = 0; i < 1500; i++) begin
      a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 12) begin
        d = $urandom;
        if (a == 2'd1) d = (d & 32'hFFFF_FFFC) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
`ifdef LED_BLINK_EN
        if (a == 2'd2) d = 32'd0;
`endif
        step(1, a, d);
      end else begin
        step(0, a, 32'd0);
      end
    end

    // Auto-refresh: evenly spaced Starts, data unchanged.
    do_reset(2);
    model_on = 1'b0;
    starts_q.delete();
    sdata_q.delete();
    step(1, 2'd0, 32'h00C0_FFEE);
    step(1, 2'd1, 32'd3);
    for (int i = 0; i < 1100; i++) step(0, 2'd0, 32'd0);
    check("refresh_count", {31'd0, starts_q.size() >= 5}, 32'd1);
    for (int k = 0; k < starts_q.size(); k++) begin
      check("refresh_data", sdata_q[k], 32'h00C0_FFEE);
      if (k >= 2) check("refresh_gap", 32'(starts_q[k] - starts_q[k - 1]), 32'(R));
    end

    // Reset in the middle of a guard window.
    do_reset(2);
    model_on = 1'b1;
    step(1, 2'd0, 32'hDEAD_BEEF);
    step(1, 2'd1, 32'd1);
    for (int i = 0; i < 6; i++) step(0, 2'd3, 32'd0);
    do_reset(1);
    step(0, 2'd3, 32'd0);
    check("rst_busy", {31'd0, obs_rdata[0]}, 32'd0);
    check("rst_pdata", obs_pdata, 32'd0);

`ifdef LED_BLINK_EN
    // Blink: masked byte alternates dark/lit at each phase toggle.
    do_reset(2);
    model_on = 1'b0;
    starts_q.delete();
    sdata_q.delete();
    step(1, 2'd0, 32'hFFFF_FFFF);
    step(1, 2'd2, 32'h0000_00FF);
    step(1, 2'd1, 32'd1);
    for (int i = 0; i < 800; i++) step(0, 2'd0, 32'd0);
    check("blink_count", {31'd0, starts_q.size() >= 6}, 32'd1);
    for (int k = 2; k < starts_q.size(); k++) begin
      check("blink_gap", 32'(starts_q[k] - starts_q[k - 1]), 32'(B));
      check("blink_value", {31'd0, (sdata_q[k] == 32'hFFFF_FF00) || (sdata_q[k] == 32'hFFFF_FFFF)}, 32'd1);
      check("blink_alternate", {31'd0, sdata_q[k] != sdata_q[k - 1]}, 32'd1);
    end
`else
    // Without blink support the mask register does not exist.
    step(1, 2'd2, 32'h0000_00FF);
    step(0, 2'd2, 32'd0);
    check("blink_absent", obs_rdata, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
